// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, datapath widths and the
// sequential PC step used by the fetch controller.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_FETCH = FETCH,
        ST_WAIT  = WAIT,
        ST_EXEC  = EXEC,
        ST_HALT  = HALT
    } fetch_state_t;

    // Branch targets are word aligned, so only the word index of the target is taken.
    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0] pc,
        input logic              take_branch,
        input logic [ADDR_W-3:0] target_word
    );
        next_pc = take_branch ? {target_word, 2'b00} : pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Counts WAIT cycles of one fetch and flags the cycle in which the limit is
// reached. Only instantiated when PC_FETCH_TIMEOUT_EN is defined.
module fetch_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // expired marks the TIMEOUT_CYCLES-th WAIT cycle, so an ack in that same cycle still wins.
    assign expired = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Multi-cycle fetch controller: owns the PC, requests instructions, presents
// them to execute and commits the next PC. PC_FETCH_TIMEOUT_EN adds fetch_err.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Branch,
    input  logic               Zero,
    input  logic [ADDR_W-1:0]  Addr_result,
    input  logic               stall,
    input  logic               halt,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  branch_base_addr,
    output logic               halted
`ifdef PC_FETCH_TIMEOUT_EN
    ,
    output logic               fetch_err
`endif
);

    fetch_state_t state;

    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr_result[1:0];

    assign imem_addr        = PC;
    assign branch_base_addr = PC;

`ifdef PC_FETCH_TIMEOUT_EN
    logic timeout_hit;

    fetch_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clr    (state == ST_FETCH),
        .en     (state == ST_WAIT),
        .expired(timeout_hit)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Outputs are set on the transition into each state so they always match the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            PC          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end
`ifdef PC_FETCH_TIMEOUT_EN
                    else if (timeout_hit) begin
                        imem_req  <= 1'b0;
                        halted    <= 1'b1;
                        fetch_err <= 1'b1;
                        state     <= ST_HALT;
                    end
`endif
                end
                ST_EXEC: begin
                    // Stall outranks halt, which outranks the PC commit.
                    if (stall) begin
                        state <= ST_EXEC;
                    end else if (halt) begin
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                        state       <= ST_HALT;
                    end else begin
                        PC          <= next_pc(PC, Branch && Zero, Addr_result[ADDR_W-1:2]);
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule
